// File: rtl/mux3_pkg.sv
// Shared select encodings and types for the three-input datapath selector.
package mux3_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_D0   = 2'b00;
  localparam sel_t SEL_D1   = 2'b01;
  localparam sel_t SEL_D2   = 2'b10;
  localparam sel_t SEL_RSVD = 2'b11;

endpackage : mux3_pkg

// File: rtl/flopenr_sync.sv
// Enabled register with synchronous active-high reset; reset wins over enable.
module flopenr_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    // NOTE: the hold value is assigned first so every path writes data_d; no latch is inferred.
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so all flops sample pre-edge values in the same step.
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule : flopenr_sync

// File: rtl/mux3_sel.sv
// Three-input WIDTH-bit selector: combinational y plus registered y_q and illegal-select flag.
module mux3_sel
  import mux3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  sel_t             s,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             sel_err
);

  logic [WIDTH-1:0] y_d;
  logic             sel_err_d;

  // s[1] has priority, so the reserved code aliases d2; an unknown select drives X.
  always_comb begin
    y_d = 'x;
    unique case (s)
      SEL_D0:   y_d = d0;
      SEL_D1:   y_d = d1;
      SEL_D2:   y_d = d2;
      SEL_RSVD: y_d = d2;
      default:  y_d = 'x;
    endcase
    sel_err_d = (s == SEL_RSVD);
  end

  assign y = y_d;

  flopenr_sync #(.WIDTH(WIDTH)) u_y_reg (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (y_d),
    .q     (y_q)
  );

  flopenr_sync #(.WIDTH(1)) u_sel_err_reg (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (sel_err_d),
    .q     (sel_err)
  );

endmodule : mux3_sel

// File: tb/tb_mux3_sel.sv
// Directed bench for mux3_sel: expectations queued on stimulus, popped at each observation.
module tb_mux3_sel;
  import mux3_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] d0, d1, d2;
  sel_t             s;
  logic             en;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             sel_err;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_compared;
  int   n_mismatched;

  mux3_sel #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .s       (s),
    .en      (en),
    .y       (y),
    .y_q     (y_q),
    .sel_err (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [WIDTH-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [WIDTH-1:0] observed);
    exp_t e;
    n_compared++;
    if (sb.size() == 0) begin
      n_mismatched++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.val)
      else begin
        n_mismatched++;
        $error("FAIL %s observed=%h expected=%h", e.tag, observed, e.val);
      end
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset = 1'b0;
    en    = 1'b0;
    d0    = 8'hFF;
    d1    = 8'h00;
    d2    = 8'h0F;

    // Combinational decode
    s = SEL_D0;   push("y_s00", 8'hFF); #10; check(y);
    s = SEL_D1;   push("y_s01", 8'h00); #10; check(y);
    s = SEL_D2;   push("y_s10", 8'h0F); #10; check(y);
    s = SEL_RSVD; push("y_s11", 8'h0F); #10; check(y);

    // Reserved select sets sel_err; a legal select clears it
    en = 1'b1;
    push("sel_err_rsvd", 8'h01);
    push("y_q_rsvd", 8'h0F);
    tick();
    check({7'b0, sel_err});
    check(y_q);
    s = SEL_D2;
    push("sel_err_clear", 8'h00);
    tick();
    check({7'b0, sel_err});

    // Reset clears registers while y keeps tracking s
    reset = 1'b1;
    en    = 1'b0;
    s     = SEL_D1;
    push("y_during_reset", 8'h00); #1; check(y);
    push("y_q_reset", 8'h00);
    push("sel_err_reset", 8'h00);
    tick();
    check(y_q);
    check({7'b0, sel_err});
    s = SEL_D2;
    push("y_after_reset_edge", 8'h0F); #1; check(y);

    // First enabled edge after reset: one-cycle latency
    reset = 1'b0;
    en    = 1'b1;
    s     = SEL_D0;
    push("y_q_before_edge", 8'h00); #1; check(y_q);
    push("y_q_load_ff", 8'hFF);
    tick();
    check(y_q);

    // Hold with en low across three edges
    en = 1'b0;
    s  = SEL_D1;
    push("y_hold_comb", 8'h00); #1; check(y);
    for (int i = 0; i < 3; i++) begin
      push($sformatf("y_q_hold_%0d", i), 8'hFF);
      tick();
      check(y_q);
    end
    en = 1'b1;
    push("y_q_reload", 8'h00);
    tick();
    check(y_q);

    // Reset beats enable on the same edge
    reset = 1'b1;
    en    = 1'b1;
    s     = SEL_D2;
    push("y_q_reset_prio", 8'h00);
    push("sel_err_reset_prio", 8'h00);
    tick();
    check(y_q);
    check({7'b0, sel_err});
    reset = 1'b0;

    // Data-only change on the selected input
    en = 1'b0;
    s  = SEL_D1;
    d1 = 8'hA5;
    push("y_data_change", 8'hA5); #1; check(y);
    en = 1'b1;
    push("y_q_data_change", 8'hA5);
    tick();
    check(y_q);
    en = 1'b0;

    // Every queued expectation must have been consumed
    n_compared++;
    assert (sb.size() === 0)
    else begin
      n_mismatched++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #5000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_mux3_sel

// File: doc/mux3_sel.md
Name: mux3_sel

Overview:
- Three-input, WIDTH-bit data selector for the processor datapath (e.g. forwarding and result-source selection).
- Primary output y is purely combinational and follows d0/d1/d2 under a 2-bit select.
- A registered copy y_q and a registered illegal-select flag are also provided for pipelined consumers and for debug.

Parameters:
- WIDTH, 8, data width of d0, d1, d2, y and y_q.

Ports:
- clk  input  1  rising-edge clock; used only by the registered outputs.
- reset  input  1  synchronous, active-high reset.
- d0  input  WIDTH  data input selected when s = 2'b00.
- d1  input  WIDTH  data input selected when s = 2'b01.
- d2  input  WIDTH  data input selected when s = 2'b10 (also 2'b11).
- s  input  2  select.
- en  input  1  load enable for y_q and sel_err.
- y  output  WIDTH  combinational selected data.
- y_q  output  WIDTH  registered selected data.
- sel_err  output  1  registered flag: last enabled load saw s = 2'b11.

Interface decision:
- One clock, clk.
- Reset is synchronous and active-high, named reset.
- No asynchronous paths other than the combinational y.

Behaviour:
- y decode (zero cycles, no dependence on clk or reset):
  - s = 00 -> y = d0.
  - s = 01 -> y = d1.
  - s = 10 -> y = d2.
  - s = 11 -> y = d2, i.e. s[1] has priority: y = s[1] ? d2 : (s[0] ? d1 : d0).
- y must be fully defined for any known s.
- y must settle within the same simulation time step as an input change, and must be stable well within 10 time units.
- If s contains X/Z, y is X. Do not mask this; the simulation must expose it.
- Registered outputs:
  - On rising clk with reset = 1: y_q <= 0 and sel_err <= 0. Reset has priority over en.
  - On rising clk with reset = 0 and en = 1: y_q <= y (the value at that edge), sel_err <= (s == 2'b11).
  - On rising clk with reset = 0 and en = 0: y_q and sel_err hold.
  - Latency from inputs to y_q is 1 cycle.
- Reset does not affect y; y remains valid during and after reset.
- y_q and sel_err values before the first reset are undefined.
- Reset asserted mid-stream clears the registers on the next edge. The first enabled edge after reset deasserts loads normally.
- Simultaneous change of s and d* in one time step: y reflects the new s and new data together, with no glitch requirement.

Decomposition:
- Shared package mux3_pkg holds:
  - SEL_D0 = 2'b00, SEL_D1 = 2'b01, SEL_D2 = 2'b10, SEL_RSVD = 2'b11.
  - typedef sel_t = logic [1:0].
- One natural sub-module: flopenr_sync, a WIDTH-parameterized enabled register with synchronous active-high reset. It is instantiated for y_q; sel_err uses a 1-bit instance.
- Select decode stays inline as an always_comb case on sel_t constants.

Test Plan:
- Common stimulus: d0 = 8'hFF, d1 = 8'h00, d2 = 8'h0F.
- Combinational select: apply s = 00, 01, 10, waiting 10 time units after each -> y === 8'hFF, then 8'h00, then 8'h0F. Checks use case equality.
- Reserved select: s = 11 -> y === 8'h0F. With en = 1, after one clk edge sel_err = 1. Then s = 10 with en = 1, after the next edge sel_err = 0.
- Register path: reset = 1 for one edge -> y_q = 8'h00 and sel_err = 0, while y still tracks s. Then en = 1 and s = 00 -> y_q = 8'hFF after exactly one edge.
- Hold:
  - y_q = 8'hFF, en = 0, s changes to 01 -> y = 8'h00 immediately; y_q stays 8'hFF across 3 edges.
  - en = 1 -> y_q = 8'h00 on the next edge.
- Reset priority: reset = 1 and en = 1 on the same edge with s = 10 -> y_q = 8'h00, not 8'h0F.
- Data-only change: s = 01 fixed, d1 changes 8'h00 -> 8'hA5 -> y = 8'hA5 in the same time step, and y_q = 8'hA5 after the next enabled edge.
